// File: rtl/register_file.sv
// register_file: N x WORD_LENGTH register file, one synchronous write port, two combinational read ports.
// Register 0 and any index >= N read as zero and ignore writes.
module register_file #(
    parameter int WORD_LENGTH = 32,
    parameter int N           = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWrite,
    input  logic [4:0]             WriteRegister,
    input  logic [4:0]             ReadRegister1,
    input  logic [4:0]             ReadRegister2,
    input  logic [WORD_LENGTH-1:0] WriteData,
    output logic [WORD_LENGTH-1:0] ReadData1,
    output logic [WORD_LENGTH-1:0] ReadData2
);
    logic [WORD_LENGTH-1:0] regs_q [N];
    logic [WORD_LENGTH-1:0] regs_d [N];

    // Decoded per index so out-of-range addresses simply match nothing.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < N; i++)
            if (RegWrite && WriteRegister == 5'(i)) regs_d[i] = WriteData;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) regs_q <= '{default: '0};
        else regs_q <= regs_d;

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        for (int i = 1; i < N; i++) begin
            if (ReadRegister1 == 5'(i)) ReadData1 = regs_q[i];
            if (ReadRegister2 == 5'(i)) ReadData2 = regs_q[i];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test of register_file (N=32 and N=8 instances) against a behavioural array model.
module tb_register_file;
    logic        clk = 0;
    logic        reset = 1;
    logic        RegWrite = 0;
    logic [4:0]  WriteRegister = 0, ReadRegister1 = 0, ReadRegister2 = 0;
    logic [31:0] WriteData = 0;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] m [2][32] = '{default: '0};
    int          lim [2] = '{32, 8};

    register_file #(.WORD_LENGTH(32), .N(32)) dut_a (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .WriteData(WriteData),
        .ReadData1(rd1_a), .ReadData2(rd2_a));

    register_file #(.WORD_LENGTH(32), .N(8)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .WriteData(WriteData),
        .ReadData1(rd1_b), .ReadData2(rd2_b));

    always #5 clk = ~clk;

    // Model: an array per instance, zero on reset, written when enabled and index is legal.
    always @(posedge clk or posedge reset)
        for (int k = 0; k < 2; k++)
            if (reset) m[k] = '{default: '0};
            else if (RegWrite && WriteRegister != 0 && int'(WriteRegister) < lim[k])
                m[k][WriteRegister] = WriteData;

    function automatic logic [31:0] model_rd(int k, logic [4:0] idx);
        if (reset || idx == 0 || int'(idx) >= lim[k]) return 0;
        return m[k][idx];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rd1_n32", rd1_a, model_rd(0, ReadRegister1));
        chk("model_rd2_n32", rd2_a, model_rd(0, ReadRegister2));
        chk("model_rd1_n8", rd1_b, model_rd(1, ReadRegister1));
        chk("model_rd2_n8", rd2_b, model_rd(1, ReadRegister2));
    end

    task automatic wr(logic [4:0] a, logic [31:0] d);
        RegWrite = 1; WriteRegister = a; WriteData = d;
        @(posedge clk); #2;
        RegWrite = 0;
    endtask

    task automatic rd(string nm, logic [4:0] a, logic [4:0] b, logic [31:0] e1, logic [31:0] e2);
        ReadRegister1 = a; ReadRegister2 = b; #1;
        chk({nm, "_rd1"}, rd1_a, e1);
        chk({nm, "_rd2"}, rd2_a, e2);
    endtask

    initial begin
        #7 reset = 0;
        rd("rst_r0", 0, 0, 0, 0);
        rd("rst_r2", 2, 2, 0, 0);
        rd("rst_r31", 31, 31, 0, 0);
        @(posedge clk); #2;
        wr(2, 7); wr(4, 20); wr(25, 6); wr(31, 78);
        rd("r2", 2, 2, 7, 7);
        rd("r4", 4, 4, 20, 20);
        rd("r25_r2", 25, 2, 6, 7);
        rd("r31", 31, 31, 78, 78);
        wr(0, 3);
        rd("r0", 0, 0, 0, 0);
        RegWrite = 0; WriteRegister = 2; WriteData = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #2 rd("we_off", 2, 2, 7, 7);
        ReadRegister1 = 4; ReadRegister2 = 31;
        RegWrite = 1; WriteRegister = 4; WriteData = 32'h55; #1;
        chk("rdw_before", rd1_a, 20);
        chk("rdw_other_before", rd2_a, 78);
        @(posedge clk); #1;
        chk("rdw_after", rd1_a, 32'h55);
        chk("rdw_other_after", rd2_a, 78);
        #1 RegWrite = 0;
        wr(5, 32'h5); wr(9, 32'h99); wr(13, 32'h13);
        ReadRegister1 = 9; ReadRegister2 = 5; #1;
        chk("oor_n32_r9", rd1_a, 32'h99);
        chk("oor_n8_r9", rd1_b, 0);
        chk("oor_n8_alias_r5", rd2_b, 32'h5);
        ReadRegister1 = 13; #1;
        chk("oor_n8_r13", rd1_b, 0);
        ReadRegister1 = 4; ReadRegister2 = 31;
        @(posedge clk); #3;
        RegWrite = 1; WriteRegister = 2; WriteData = 32'hAA;
        reset = 1; #1;
        chk("async_rst_rd1", rd1_a, 0);
        chk("async_rst_rd2", rd2_a, 0);
        @(posedge clk); #1;
        RegWrite = 0;
        #1 reset = 0;
        rd("post_rst_r2", 2, 4, 0, 0);
        wr(2, 32'h11);
        rd("post_rst_wr", 2, 31, 32'h11, 0);
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
